// File: rtl/rr_arb_n.sv
// ---------------------------------------------------------------------------
// rr_arb_n
// N-way round-robin AXI-Stream arbiter with weighted bursts and a source-ID
// sideband. Merges N_INPUTS slave streams onto one master stream. A winner
// may keep top priority for up to BURST consecutive transfer units. A unit
// is a whole packet (TLAST_ARB=1) or a single flit (TLAST_ARB=0).
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   s_TDATA/TVALID/     slave streams, stream i at [i*DATA_WIDTH +: DATA_WIDTH]
//   s_TLAST/s_TREADY    (at most one s_TREADY bit is high at a time)
//   o_TDATA/TVALID/     merged master stream
//   o_TLAST/o_TREADY
//   o_TID               index of the source stream of the current flit
//
// PIPE_STAGE=1 puts a 2-entry skid buffer on the output so that the upstream
// ready is a flop; PIPE_STAGE=0 gives a purely combinational output.
// ---------------------------------------------------------------------------
module rr_arb_n #(
    parameter int DATA_WIDTH = 32,
    parameter int N_INPUTS   = 4,
    parameter int TLAST_ARB  = 1,
    parameter int BURST      = 1,
    parameter int PIPE_STAGE = 1,
    localparam int IDW = (N_INPUTS > 2) ? $clog2(N_INPUTS) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_INPUTS*DATA_WIDTH-1:0] s_TDATA,
    input  logic [N_INPUTS-1:0]            s_TVALID,
    output logic [N_INPUTS-1:0]            s_TREADY,
    input  logic [N_INPUTS-1:0]            s_TLAST,
    output logic [DATA_WIDTH-1:0]          o_TDATA,
    output logic                           o_TVALID,
    input  logic                           o_TREADY,
    output logic                           o_TLAST,
    output logic [IDW-1:0]                 o_TID
);
    localparam int              IW1      = IDW + 1;
    localparam int              ENTRY_W  = DATA_WIDTH + 1 + IDW;
    localparam logic [IDW-1:0]  LAST_IDX = IDW'(N_INPUTS - 1);

    logic [IDW-1:0]        ptr_q, ptr_d;
    logic                  lock_q, lock_d;
    logic [IDW-1:0]        sel_q, sel_d;
    logic [IDW-1:0]        last_win_q, last_win_d;
    logic [7:0]            cnt_q, cnt_d;

    logic [IDW-1:0]        grant;
    logic [IW1-1:0]        scan_idx;
    logic                  found;
    logic                  mux_valid;
    logic                  mux_last;
    logic [DATA_WIDTH-1:0] mux_data;
    logic                  int_ready;
    logic                  xfer;
    logic                  unit_end;
    logic [8:0]            burst_n;

    // Grant selection. When locked the held selection wins regardless of
    // valids; otherwise scan from ptr upward with an explicit wrap so that
    // non-power-of-2 N_INPUTS never indexes past the last stream.
    always_comb begin
        grant    = ptr_q;
        found    = 1'b0;
        scan_idx = '0;
        if (lock_q) begin
            grant = sel_q;
        end else begin
            for (int k = 0; k < N_INPUTS; k++) begin
                scan_idx = {1'b0, ptr_q} + IW1'(k);
                if (scan_idx >= IW1'(N_INPUTS)) begin
                    scan_idx = scan_idx - IW1'(N_INPUTS);
                end
                if (!found && s_TVALID[scan_idx[IDW-1:0]]) begin
                    found = 1'b1;
                    grant = scan_idx[IDW-1:0];
                end
            end
        end
    end

    // Data/valid/last mux and the one-hot upstream ready.
    always_comb begin
        mux_valid       = s_TVALID[grant];
        mux_last        = s_TLAST[grant];
        mux_data        = s_TDATA[grant*DATA_WIDTH +: DATA_WIDTH];
        s_TREADY        = '0;
        s_TREADY[grant] = int_ready;
        xfer            = mux_valid && int_ready;
        unit_end        = (TLAST_ARB != 0) ? mux_last : 1'b1;
    end

    // Arbitration state update. A stalled offer or an unfinished packet
    // freezes the selection; a finished unit either keeps the winner on top
    // (quota left) or passes priority to the next index.
    always_comb begin
        ptr_d      = ptr_q;
        lock_d     = lock_q;
        sel_d      = sel_q;
        last_win_d = last_win_q;
        cnt_d      = cnt_q;
        burst_n    = (grant == last_win_q) ? ({1'b0, cnt_q} + 9'd1) : 9'd1;
        if (mux_valid && !int_ready) begin
            lock_d = 1'b1;
            sel_d  = grant;
        end else if (xfer) begin
            if (!unit_end) begin
                lock_d = 1'b1;
                sel_d  = grant;
            end else begin
                lock_d     = 1'b0;
                last_win_d = grant;
                if (burst_n >= 9'(BURST)) begin
                    ptr_d = (grant == LAST_IDX) ? '0 : grant + IDW'(1);
                    cnt_d = 8'd0;
                end else begin
                    ptr_d = grant;
                    cnt_d = burst_n[7:0];
                end
            end
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            lock_q     <= 1'b0;
            sel_q      <= '0;
            last_win_q <= '0;
            cnt_q      <= 8'd0;
        end else begin
            ptr_q      <= ptr_d;
            lock_q     <= lock_d;
            sel_q      <= sel_d;
            last_win_q <= last_win_d;
            cnt_q      <= cnt_d;
        end
    end

    generate
        if (PIPE_STAGE != 0) begin : g_skid
            logic [ENTRY_W-1:0] mem_q [2];
            logic [ENTRY_W-1:0] mem_d [2];
            logic               wr_q, wr_d;
            logic               rd_q, rd_d;
            logic [1:0]         count_q, count_d;
            logic               ready_q, ready_d;
            logic               push, pop;

            // Two-entry skid FIFO. Upstream ready is registered from the
            // next occupancy, so it never depends on same-cycle o_TREADY,
            // yet one push and one pop per cycle keep full throughput.
            always_comb begin
                push  = mux_valid && ready_q;
                pop   = (count_q != 2'd0) && o_TREADY;
                mem_d = mem_q;
                if (push) begin
                    mem_d[wr_q] = {mux_data, mux_last, grant};
                end
                wr_d    = wr_q ^ push;
                rd_d    = rd_q ^ pop;
                count_d = count_q + {1'b0, push} - {1'b0, pop};
                ready_d = (count_d != 2'd2);
            end

            // Skid control registers; ready stays low through reset and the
            // first cycle after it.
            always_ff @(posedge clk) begin
                if (rst) begin
                    wr_q    <= 1'b0;
                    rd_q    <= 1'b0;
                    count_q <= 2'd0;
                    ready_q <= 1'b0;
                end else begin
                    wr_q    <= wr_d;
                    rd_q    <= rd_d;
                    count_q <= count_d;
                    ready_q <= ready_d;
                end
            end

            // Payload storage needs no reset: it is ignored while empty.
            always_ff @(posedge clk) begin
                mem_q <= mem_d;
            end

            assign int_ready                 = ready_q;
            assign o_TVALID                  = (count_q != 2'd0);
            assign {o_TDATA, o_TLAST, o_TID} = mem_q[rd_q];
        end else begin : g_comb
            assign int_ready = o_TREADY;
            assign o_TVALID  = mux_valid;
            assign o_TDATA   = mux_data;
            assign o_TLAST   = mux_last;
            assign o_TID     = grant;
        end
    endgenerate

endmodule

// File: tb/tb_rr_arb_n.sv
// ---------------------------------------------------------------------------
// tb_rr_arb_n
// Bench for rr_arb_n. Instance A (N=7, BURST=3, packet arbitration, skid
// output) runs randomized traffic against a queue-based reference model,
// including a mid-run reset and a saturated fairness window. Instance B
// (N=5, BURST=2, flit arbitration, combinational output) gets hand-computed
// sequences for the offer-hold rule and the 4->0 pointer wrap.
// ---------------------------------------------------------------------------
module tb_rr_arb_n;
    localparam int DW   = 32;
    localparam int NA   = 7;
    localparam int BA   = 3;
    localparam int IDWA = 3;
    localparam int NB   = 5;
    localparam int IDWB = 3;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        int            tid;
    } flit_t;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    logic [NA*DW-1:0] a_s_tdata;
    logic [NA-1:0]    a_s_tvalid, a_s_tready, a_s_tlast;
    logic [DW-1:0]    a_o_tdata;
    logic             a_o_tvalid, a_o_tready, a_o_tlast;
    logic [IDWA-1:0]  a_o_tid;

    logic [NB*DW-1:0] b_s_tdata;
    logic [NB-1:0]    b_s_tvalid, b_s_tready, b_s_tlast;
    logic [DW-1:0]    b_o_tdata;
    logic             b_o_tvalid, b_o_tready, b_o_tlast;
    logic [IDWB-1:0]  b_o_tid;

    int errors = 0;
    int checks = 0;

    // Reference model state for instance A.
    flit_t m_q[$];
    int    m_ptr, m_owner, m_last_win, m_cnt, m_grant;
    bit    m_locked, m_fresh, m_ready;
    bit    pend[NA];
    int    seq[NA];
    bit    just_reset;
    bit    did_reset;
    int    fair_cnt[NA];
    int    fair_total;
    int    exp_wrap[8];

    rr_arb_n #(
        .DATA_WIDTH(DW), .N_INPUTS(NA), .TLAST_ARB(1), .BURST(BA), .PIPE_STAGE(1)
    ) dut_a (
        .clk(clk), .rst(rst_a),
        .s_TDATA(a_s_tdata), .s_TVALID(a_s_tvalid), .s_TREADY(a_s_tready), .s_TLAST(a_s_tlast),
        .o_TDATA(a_o_tdata), .o_TVALID(a_o_tvalid), .o_TREADY(a_o_tready), .o_TLAST(a_o_tlast),
        .o_TID(a_o_tid)
    );

    rr_arb_n #(
        .DATA_WIDTH(DW), .N_INPUTS(NB), .TLAST_ARB(0), .BURST(2), .PIPE_STAGE(0)
    ) dut_b (
        .clk(clk), .rst(rst_b),
        .s_TDATA(b_s_tdata), .s_TVALID(b_s_tvalid), .s_TREADY(b_s_tready), .s_TLAST(b_s_tlast),
        .o_TDATA(b_o_tdata), .o_TVALID(b_o_tvalid), .o_TREADY(b_o_tready), .o_TLAST(b_o_tlast),
        .o_TID(b_o_tid)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic checkVal(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic modelReset();
        m_q.delete();
        m_ptr      = 0;
        m_owner    = 0;
        m_last_win = 0;
        m_cnt      = 0;
        m_locked   = 1'b0;
        m_fresh    = 1'b1;
    endtask

    // Holds rst_a for n cycles with all sources idle; any offer in flight is
    // abandoned, as the upstream would do on a reset.
    task automatic pulseResetA(input int n);
        rst_a      = 1'b1;
        a_s_tvalid = '0;
        a_o_tready = 1'b1;
        for (int i = 0; i < NA; i++) pend[i] = 1'b0;
        repeat (n) @(negedge clk);
        rst_a      = 1'b0;
        modelReset();
        just_reset = 1'b1;
    endtask

    task automatic pulseResetB(input int n);
        rst_b      = 1'b1;
        b_s_tvalid = '0;
        b_o_tready = 1'b0;
        repeat (n) @(negedge clk);
        rst_b      = 1'b0;
    endtask

    // New random offers only from sources with nothing outstanding, so a
    // valid that has not been accepted keeps its data and last stable.
    task automatic applyStimulus(input int valid_pct, input int ready_pct);
        for (int i = 0; i < NA; i++) begin
            if (!pend[i]) begin
                if ($urandom_range(99) < valid_pct) begin
                    a_s_tvalid[i]              = 1'b1;
                    a_s_tdata[i*DW +: DW]      = {8'(i), 24'(seq[i])};
                    a_s_tlast[i]               = ($urandom_range(2) == 0);
                    seq[i]                     = seq[i] + 1;
                    pend[i]                    = 1'b1;
                end else begin
                    a_s_tvalid[i] = 1'b0;
                end
            end
        end
        a_o_tready = ($urandom_range(99) < ready_pct);
    endtask

    // Expected outputs of instance A from the model: who is offered, whether
    // the buffer has room, and what sits at the head of the output queue.
    task automatic checkOutput();
        logic [NA-1:0] exp_ready;
        m_ready = !m_fresh && (m_q.size() < 2);
        if (m_locked) begin
            m_grant = m_owner;
        end else begin
            m_grant = m_ptr;
            for (int k = 0; k < NA; k++) begin
                if (a_s_tvalid[(m_ptr + k) % NA]) begin
                    m_grant = (m_ptr + k) % NA;
                    break;
                end
            end
        end
        exp_ready = '0;
        if (m_ready) exp_ready[m_grant] = 1'b1;
        checkVal("a_s_tready", a_s_tready, exp_ready);
        checkVal("a_o_tvalid", a_o_tvalid, (m_q.size() != 0));
        if (m_q.size() != 0) begin
            checkVal("a_o_tdata", a_o_tdata, m_q[0].data);
            checkVal("a_o_tlast", a_o_tlast, m_q[0].last);
            checkVal("a_o_tid",   a_o_tid,   m_q[0].tid);
        end
    endtask

    // Advance the model across the coming clock edge.
    task automatic modelStep();
        flit_t f;
        int    n;
        bit    v;
        v = a_s_tvalid[m_grant];
        if (m_q.size() != 0 && a_o_tready) void'(m_q.pop_front());
        if (v && !m_ready) begin
            m_locked = 1'b1;
            m_owner  = m_grant;
        end else if (v && m_ready) begin
            f.data = a_s_tdata[m_grant*DW +: DW];
            f.last = a_s_tlast[m_grant];
            f.tid  = m_grant;
            m_q.push_back(f);
            pend[m_grant] = 1'b0;
            if (!f.last) begin
                m_locked = 1'b1;
                m_owner  = m_grant;
            end else begin
                m_locked   = 1'b0;
                n          = (m_grant == m_last_win) ? m_cnt + 1 : 1;
                m_last_win = m_grant;
                if (n >= BA) begin
                    m_ptr = (m_grant + 1) % NA;
                    m_cnt = 0;
                end else begin
                    m_ptr = m_grant;
                    m_cnt = n;
                end
            end
        end
        m_fresh = 1'b0;
    endtask

    task automatic cycleA(input int valid_pct, input int ready_pct);
        applyStimulus(valid_pct, ready_pct);
        #1;
        if (just_reset) begin
            checkVal("reset_o_tvalid", a_o_tvalid, 1'b0);
            checkVal("reset_s_tready", a_s_tready, '0);
            just_reset = 1'b0;
        end
        checkOutput();
        modelStep();
    endtask

    // Main sequence: random traffic on A, fairness window, directed B checks.
    initial begin
        rst_a      = 1'b1;
        rst_b      = 1'b1;
        a_s_tdata  = '0;
        a_s_tvalid = '0;
        a_s_tlast  = '0;
        a_o_tready = 1'b0;
        b_s_tdata  = '0;
        b_s_tvalid = '0;
        b_s_tlast  = '0;
        b_o_tready = 1'b0;
        did_reset  = 1'b0;
        fair_total = 0;
        for (int i = 0; i < NA; i++) begin
            pend[i]     = 1'b0;
            seq[i]      = 0;
            fair_cnt[i] = 0;
        end
        modelReset();

        @(negedge clk);
        pulseResetA(3);

        for (int c = 0; c < 10000 && errors < 50; c++) begin
            if (!did_reset && c >= 5000 && (m_locked || c == 9000)) begin
                did_reset = 1'b1;
                pulseResetA(2);
            end
            cycleA(60, 70);
            @(negedge clk);
        end

        for (int c = 0; c < 1400 && errors < 50; c++) begin
            cycleA(100, 100);
            if (c >= 20 && a_o_tvalid && a_o_tready && a_o_tlast && int'(a_o_tid) < NA) begin
                fair_cnt[a_o_tid]++;
                fair_total++;
            end
            @(negedge clk);
        end
        a_s_tvalid = '0;

        checks++;
        if (fair_total <= NA * BA) begin
            errors++;
            $display("[TB] FAIL fair_total: got %0d units, required more than %0d", fair_total, NA * BA);
        end
        for (int i = 0; i < NA; i++) begin
            checks++;
            if ((fair_cnt[i] * NA - fair_total) > BA * NA || (fair_total - fair_cnt[i] * NA) > BA * NA) begin
                errors++;
                $display("[TB] FAIL fair_share src %0d: got %0d of %0d units, required %0d/%0d +/- %0d",
                         i, fair_cnt[i], fair_total, fair_total, NA, BA);
            end
        end

        // Offer hold: stream 2 stalls, then stream 0 (top priority) appears.
        pulseResetB(2);
        b_s_tdata[2*DW +: DW] = 32'hCAFE0002;
        b_s_tdata[0 +: DW]    = 32'hCAFE0000;
        b_s_tvalid            = 5'b00100;
        b_o_tready            = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            checkVal($sformatf("hold_tid_%0d", c),   b_o_tid,    2);
            checkVal($sformatf("hold_data_%0d", c),  b_o_tdata,  32'hCAFE0002);
            checkVal($sformatf("hold_ready_%0d", c), b_s_tready, 5'b00000);
            @(negedge clk);
        end
        b_s_tvalid = 5'b00101;
        #1;
        checkVal("hold_tid_contend",  b_o_tid,   2);
        checkVal("hold_data_contend", b_o_tdata, 32'hCAFE0002);
        checkVal("hold_valid",        b_o_tvalid, 1'b1);
        @(negedge clk);
        b_o_tready = 1'b1;
        #1;
        checkVal("hold_tid_accept",   b_o_tid,    2);
        checkVal("hold_ready_accept", b_s_tready, 5'b00100);
        @(negedge clk);
        b_s_tvalid = 5'b00001;
        #1;
        checkVal("after_hold_tid",   b_o_tid,    0);
        checkVal("after_hold_data",  b_o_tdata,  32'hCAFE0000);
        checkVal("after_hold_ready", b_s_tready, 5'b00001);
        @(negedge clk);

        // Burst of 2 with streams 0 and 4 both requesting; priority wraps 4->0.
        pulseResetB(2);
        exp_wrap              = '{0, 0, 4, 4, 0, 0, 4, 4};
        b_s_tdata[0 +: DW]    = 32'h000000B0;
        b_s_tdata[4*DW +: DW] = 32'h000000B4;
        b_s_tvalid            = 5'b10001;
        b_o_tready            = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            checkVal($sformatf("wrap_tid_%0d", c),  b_o_tid, exp_wrap[c]);
            checkVal($sformatf("wrap_data_%0d", c), b_o_tdata, (exp_wrap[c] == 0) ? 32'h000000B0 : 32'h000000B4);
            @(negedge clk);
        end
        b_s_tvalid = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_arb_n.md
# rr_arb_n

Parametrised N-way round-robin AXI-Stream arbiter with weighted bursts and a source-ID sideband. It merges `N_INPUTS` slave streams onto one master stream, optionally holding the grant for a whole packet (TLAST arbitration). A winner may keep the grant for up to `BURST` consecutive transfer units. It sits in the same places as the fixed 4-input switch and supersedes it: `BURST=1`, `N_INPUTS=4` gives the classic behaviour plus `o_TID`.

## Interface
- `DATA_WIDTH`, 32, TDATA width per stream.
- `N_INPUTS`, 4, number of slave streams, 2..16.
- `TLAST_ARB`, 1, 1 = transfer unit is a packet (grant held until TLAST); 0 = transfer unit is one flit, TLAST passed through but not used for arbitration.
- `BURST`, 1, transfer units a winner may take consecutively before the pointer advances, 1..255.
- `PIPE_STAGE`, 1, 1 = output through a 2-entry skid buffer; 0 = combinational output.
- Derived: `IDW` = max(1, clog2(`N_INPUTS`)).
- `clk`  in  1  sole clock, all logic on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `s_TDATA`  in  `N_INPUTS*DATA_WIDTH`  stream i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `s_TVALID`  in  `N_INPUTS`  per-stream valid.
- `s_TREADY`  out  `N_INPUTS`  per-stream ready; at most one bit high.
- `s_TLAST`  in  `N_INPUTS`  per-stream last.
- `o_TDATA`  out  `DATA_WIDTH`  merged data.
- `o_TVALID`  out  1  merged valid.
- `o_TREADY`  in  1  downstream ready.
- `o_TLAST`  out  1  merged last.
- `o_TID`  out  `IDW`  index of the source stream of the current flit.

## Operation
- State:
  - `ptr`: priority index, reset 0.
  - `lock`: selection frozen, reset 0.
  - `sel`: held grant index, reset 0.
  - `last_win`: index of the last winner, reset 0.
  - `cnt`: 8-bit count of completed units by `last_win`, reset 0.
- Unlocked: grant = first i with `s_TVALID[i]`, searching `ptr`, `ptr+1`, … modulo `N_INPUTS`, in the same cycle. If no request, grant = `ptr` and the mux output is invalid.
- Locked: grant = `sel` regardless of valids.
- Mux: muxout = stream[grant].
  - `s_TREADY[grant]` = internal ready.
  - All other `s_TREADY` = 0.
  - Internal `TID` = grant.
- Flit transfer: muxout valid && internal ready.
- Offer hold (AXI stability): if muxout is valid but not accepted, set `lock=1`, `sel`=grant. The selection cannot change under a stalled valid.
- On a transfer that does not end a unit (`TLAST_ARB=1`, TLAST=0): `lock=1`, `sel`=grant.
- On a transfer that ends a unit (TLAST=1, or any flit when `TLAST_ARB=0`):
  - `lock=0`.
  - n = (grant==`last_win`) ? `cnt`+1 : 1; `last_win`=grant.
  - If n ≥ `BURST`: `ptr`=(grant+1) mod `N_INPUTS`, `cnt`=0.
  - Else: `ptr`=grant, `cnt`=n (winner keeps top priority).
- Winner with remaining quota that drops TVALID while unlocked: the next requester after it wins. Its count restarts at 1 when it completes a unit.
- Modulo wrap: index `N_INPUTS-1` + 1 → 0. This must be correct for non-power-of-2 `N_INPUTS`.
- Reset mid-packet: all state returns to reset values and the skid buffer empties. Any partial packet is truncated; the upstream is responsible for this.

## Timing
- `PIPE_STAGE=0`:
  - Output is combinational from the inputs and state; latency 0.
  - `o_TVALID`/`o_TLAST`/`o_TID` track the selected input.
  - Internal ready = `o_TREADY`.
- `PIPE_STAGE=1`:
  - Skid buffer holds {TDATA, TLAST, TID}; latency 1 cycle.
  - Sustains 1 flit/cycle.
  - Internal ready registered (high when the buffer has a free entry), independent of same-cycle `o_TREADY`.
- Reset values:
  - `o_TVALID`=0, `s_TREADY`=0 for 1 cycle after reset release when `PIPE_STAGE=1`.
  - Combinational outputs follow state when `PIPE_STAGE=0`.
  - `o_TDATA`/`o_TLAST`/`o_TID` are don't-care while `o_TVALID`=0.
- Back-to-back packets from different sources: no bubble.
  - Arbitration for the next unit occurs in the same cycle the previous unit's last flit transfers (state update at that edge).
  - The new winner may transfer on the next cycle.
- No `s_TREADY` bit is high for a stream that is not selected; no combinational path from `o_TREADY` to `o_TVALID`.

## Test plan
- N=4, BURST=1, TLAST_ARB=1, PIPE=1; all streams send 3-flit packets continuously → `o_TID` sequence 0,0,0,1,1,1,2,2,2,3,3,3,0… with `o_TVALID` high every cycle after the first.
- N=5, BURST=2, TLAST_ARB=0, PIPE=0; streams 0 and 4 always valid → `o_TID` 0,0,4,4,0,0,…; checks wrap 4→0.
- TLAST_ARB=1; stream 1 mid-packet drops TVALID for 3 cycles while stream 2 is valid → `s_TREADY[2]` stays 0 and stream 1's packet completes contiguously on output.
- PIPE=0; stream 2 valid, `o_TREADY`=0 for 4 cycles, then stream 0 (`ptr`=0) raises valid → `o_TID` stays 2 and TDATA stays stable until acceptance.
- Random valids/ready/TLAST, N=7, BURST=3, PIPE=1, 10k cycles, with `rst` pulsed mid-packet once:
  - Scoreboard per-source ordering.
  - No interleaving within packets.
  - Per-source grant share within ±1 burst of fair.
  - `o_TVALID`=0 in the cycle after reset.
